// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its exception vector lookup.
package pipeline_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STALL_W = 6;

    localparam logic [XLEN-1:0] EXC_NONE         = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_INT          = 32'h0000_0001;
    localparam logic [XLEN-1:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [XLEN-1:0] EXC_BREAK        = 32'h0000_0009;
    localparam logic [XLEN-1:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [XLEN-1:0] EXC_OV           = 32'h0000_000c;
    localparam logic [XLEN-1:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [XLEN-1:0] EXC_ERET         = 32'h0000_000e;

    // Bit order: pc, if, id, ex, mem, wb; a requester holds itself and every older stage.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    // Highest-priority requester (mem > ex > id > if) selects the stall pattern.
    function automatic logic [STALL_W-1:0] stall_merge(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_W-1:0] res;
        res = STALL_NONE;
        if (req_mem)     res = STALL_MEM;
        else if (req_ex) res = STALL_EX;
        else if (req_id) res = STALL_ID;
        else if (req_if) res = STALL_IF;
        return res;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_exc_vector_map.sv
// Combinational exception type / EPC to redirect PC lookup, shared with cp0.
module exc_vector_map
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] INT_VECTOR = 32'h0000_0020,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic [XLEN-1:0] excepttype,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] vector_c
);

    always_comb begin
        vector_c = '0;
        unique case (excepttype)
            EXC_NONE:   vector_c = '0;
            EXC_INT:    vector_c = INT_VECTOR;
            EXC_ERET:   vector_c = epc;
            EXC_SYSCALL, EXC_BREAK, EXC_INST_INVALID, EXC_OV, EXC_TRAP:
                        vector_c = EXC_VECTOR;
            default:    vector_c = EXC_VECTOR;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stall merge, exception flush/redirect, post-flush recovery,
// stall watchdog and performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] INT_VECTOR  = 32'h0000_0020,
    parameter logic [XLEN-1:0] EXC_VECTOR  = 32'h0000_0040,
    parameter int unsigned     WDOG_LIMIT  = 1024,
    parameter int unsigned     FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_from_if,
    input  logic                   stallreq_from_id,
    input  logic                   stallreq_from_ex,
    input  logic                   stallreq_from_mem,
    input  logic [XLEN-1:0]        excepttype_i,
    input  logic [XLEN-1:0]        cp0_epc_i,
    output logic [STALL_W-1:0]     stall,
    output logic                   flush,
    output logic [XLEN-1:0]        new_pc,
    output logic [XLEN-1:0]        stall_cycles_o,
    output logic [FLUSH_CNT_W-1:0] flush_count_o,
    output logic                   stall_timeout_o
);

    localparam int unsigned         WDOG_W    = 16;
    localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    state_e            state_q;
    state_e            state_d;
    logic              exc;
    logic [XLEN-1:0]   vector;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              stalled;

    exc_vector_map #(
        .INT_VECTOR (INT_VECTOR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_exc_vector_map (
        .excepttype (excepttype_i),
        .epc        (cp0_epc_i),
        .vector_c   (vector)
    );

    assign exc     = (excepttype_i != EXC_NONE);
    assign stalled = (stall != STALL_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state and zero-latency control outputs; exception overrides all stall requests.
    always_comb begin
        state_d = state_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = '0;
        if (exc) begin
            flush   = 1'b1;
            new_pc  = vector;
            state_d = ST_RECOVER;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    stall = stall_merge(stallreq_from_if, stallreq_from_id,
                                        stallreq_from_ex, stallreq_from_mem);
                end
                ST_RECOVER: begin
                    // id/ex/mem requests come from slots that were just flushed.
                    stall   = stall_merge(stallreq_from_if, 1'b0, 1'b0, 1'b0);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (!rst) begin
            stall  = STALL_NONE;
            flush  = 1'b0;
            new_pc = '0;
        end
    end

    // Performance counters and stall watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_o  <= '0;
            flush_count_o   <= '0;
            wdog_cnt        <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            if (stalled && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + XLEN'(1);
            end
            if (flush) begin
                flush_count_o <= flush_count_o + FLUSH_CNT_W'(1);
            end
            if (flush || !stalled) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_LAST) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (stalled && (wdog_cnt == WDOG_LAST)) begin
                stall_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed plan scenarios plus random traffic against a rule-level model.
module tb_pipeline_ctrl;

    localparam int unsigned WDOG = 4;

    logic        clk;
    logic        rst;
    logic        req_if, req_id, req_ex, req_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
    logic        stall_timeout_o;

    pipeline_ctrl #(
        .INT_VECTOR  (32'h0000_0020),
        .EXC_VECTOR  (32'h0000_0040),
        .WDOG_LIMIT  (WDOG),
        .FLUSH_CNT_W (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (req_if),
        .stallreq_from_id  (req_id),
        .stallreq_from_ex  (req_ex),
        .stallreq_from_mem (req_mem),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cycles_o    (stall_cycles_o),
        .flush_count_o     (flush_count_o),
        .stall_timeout_o   (stall_timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Model state: whether the previous cycle took an exception, and plain counters.
    bit      m_after_exc;
    longint  m_stall_cycles;
    int      m_flushes;
    int      m_run;
    bit      m_timeout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_vector(input logic [31:0] et, input logic [31:0] epc);
        if (et == 32'h1)      return 32'h20;
        else if (et == 32'he) return epc;
        else                  return 32'h40;
    endfunction

    task automatic model_reset();
        m_after_exc    = 1'b0;
        m_stall_cycles = 0;
        m_flushes      = 0;
        m_run          = 0;
        m_timeout      = 1'b0;
    endtask

    // One cycle: drive just after negedge, check mid-cycle, advance model at posedge.
    task automatic step(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                        input logic [31:0] et, input logic [31:0] epc);
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        int          depth;
        rst = r; req_if = fi; req_id = fd; req_ex = fe; req_mem = fm;
        excepttype_i = et; cp0_epc_i = epc;
        #1;
        if (!r) model_reset();
        e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'd0;
        if (r) begin
            if (et != 0) begin
                e_flush = 1'b1;
                e_pc    = exp_vector(et, epc);
            end else begin
                if (m_after_exc) depth = fi ? 2 : 0;
                else depth = fm ? 5 : fe ? 4 : fd ? 3 : fi ? 2 : 0;
                e_stall = 6'((1 << depth) - 1);
            end
        end
        check("stall", 32'(stall), 32'(e_stall));
        check("flush", 32'(flush), 32'(e_flush));
        check("new_pc", new_pc, e_pc);
        check("stall_cycles", stall_cycles_o, 32'(m_stall_cycles));
        check("flush_count", 32'(flush_count_o), 32'(m_flushes % 65536));
        check("timeout", 32'(stall_timeout_o), 32'(m_timeout));
        @(posedge clk);
        if (r) begin
            m_after_exc = (et != 0);
            if (e_stall != 0 && m_stall_cycles < 64'hFFFF_FFFF) m_stall_cycles++;
            if (e_flush) m_flushes++;
            if (e_flush || e_stall == 0) m_run = 0;
            else m_run++;
            if (m_run >= int'(WDOG)) m_timeout = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_exc();
        int sel;
        sel = $urandom_range(0, 19);
        case (sel)
            0: return 32'h1;
            1: return 32'h8;
            2: return 32'h9;
            3: return 32'ha;
            4: return 32'hc;
            5: return 32'hd;
            6: return 32'he;
            7: return $urandom_range(1, 32'h7fff_ffff);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset holds everything quiet even with all requests and an exception present.
        step(0, 1, 1, 1, 1, 32'h8, 32'h0);
        step(0, 1, 1, 1, 1, 32'h8, 32'h0);
        step(1, 1, 1, 1, 1, 32'h8, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);

        // Priority merge.
        step(1, 0, 1, 1, 0, 32'h0, 32'h0);
        step(1, 0, 1, 0, 0, 32'h0, 32'h0);
        step(1, 1, 0, 0, 0, 32'h0, 32'h0);

        // Exception beats a mem stall; eret redirects to EPC.
        step(1, 0, 0, 0, 1, 32'he, 32'h0000_1234);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);

        // Recovery mask then normal merge.
        step(1, 0, 0, 0, 0, 32'h8, 32'h0);
        step(1, 1, 0, 1, 0, 32'h0, 32'h0);
        step(1, 0, 0, 1, 0, 32'h0, 32'h0);

        // Back-to-back exceptions stay in recovery.
        step(1, 0, 0, 0, 0, 32'hc, 32'h0);
        step(1, 0, 0, 0, 0, 32'hd, 32'h0);
        step(1, 0, 1, 1, 1, 32'h0, 32'h0);
        step(1, 0, 1, 1, 1, 32'h0, 32'h0);

        // Watchdog from a clean reset.
        step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        check("wd_flag_sticky", 32'(stall_timeout_o), 32'd1);
        check("wd_stall_cycles", stall_cycles_o, 32'd4);

        // Interrupt and unknown-code vectors.
        step(1, 0, 0, 0, 0, 32'h1, 32'h0);
        step(1, 0, 0, 0, 0, 32'h7, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                 rand_exc(), $urandom());
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the 6-bit stall vector consumed by all pipeline registers.
- Converts a committed mem-stage exception into a one-cycle flush plus a redirect PC.
- Runs a short post-flush recovery FSM, a stall watchdog and performance counters.
- Sits beside the cp0 block and drives if_id, id_ex, ex_mem and mem_wb.

Parameters:
- INT_VECTOR, 32'h0000_0020, redirect PC for interrupts (excepttype 32'h1).
- EXC_VECTOR, 32'h0000_0040, redirect PC for syscall/invalid-inst/trap/overflow.
- WDOG_LIMIT, 1024, consecutive stalled cycles before timeout; legal range 2..65535.
- FLUSH_CNT_W, 16, width of the flush counter.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- stallreq_from_if  in  1  fetch bus not ready.
- stallreq_from_id  in  1  load-use hazard.
- stallreq_from_ex  in  1  multi-cycle madd/msub/div busy.
- stallreq_from_mem  in  1  data bus not ready.
- excepttype_i  in  32  final exception type from mem stage; 0 = none.
- cp0_epc_i  in  32  current EPC, forwarded.
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold.
- flush  out  1  kill all in-flight instructions this cycle.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_cycles_o  out  32  count of cycles with stall!=0; saturating.
- flush_count_o  out  FLUSH_CNT_W  number of flushes; wraps.
- stall_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; stall_cycles_o=0; flush_count_o=0; stall_timeout_o=0; watchdog counter=0. Combinational outputs are forced to stall=0, flush=0, new_pc=0 while rst=0.
- Exception detect is exc = (excepttype_i != 0), accepted in any state.
  - flush=1 and stall=6'b000000 combinationally in the same cycle. Exception beats every stall request.
  - new_pc mapping: 32'h1 -> INT_VECTOR; 32'h8, 32'h9, 32'ha, 32'hc, 32'hd -> EXC_VECTOR; 32'he (eret) -> cp0_epc_i.
  - Any other nonzero value -> EXC_VECTOR.
- Stall merge when exc=0. Priority is mem > ex > id > if; the highest requester wins.
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- FSM states: IDLE, RECOVER.
  - IDLE -> RECOVER on exc.
  - RECOVER -> IDLE after exactly one cycle, unless exc occurs again, in which case it stays in RECOVER.
  - In RECOVER, stallreq_from_id/ex/mem are masked because they originate from flushed slots. Only stallreq_from_if is honoured.
- Counters (registered, update on posedge):
  - stall_cycles_o increments when stall != 0 and saturates at 32'hFFFF_FFFF.
  - flush_count_o increments on flush and wraps.
- Watchdog:
  - wdog_cnt increments while stall != 0 and clears when stall == 0 or flush == 1.
  - When wdog_cnt reaches WDOG_LIMIT-1 with stall still != 0, stall_timeout_o is set next edge and stays set until reset.
  - The watchdog has no effect on stall or flush.
- Latency: stall, flush and new_pc are 0-cycle (combinational); state and counters are 1 cycle.
- Reset mid-stall or mid-recover: asynchronous return to IDLE, all counts cleared.

Decomposition:
- Shared defines file gets: the exception type codes (EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_OV, EXC_TRAP, EXC_ERET), the stall vector patterns (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM), and the state encodings.
- One sub-module: exc_vector_map, a combinational excepttype/epc -> new_pc lookup, reusable by cp0.

Test Plan:
- Reset: rst=0 with all requests =1 and excepttype_i=32'h8 -> stall=0, flush=0, counters 0. Release rst -> flush=1, new_pc=32'h40.
- Priority: stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111. Drop ex -> 6'b000111. Drop id, raise if -> 6'b000011.
- Exception over stall: stallreq_from_mem=1 with excepttype_i=32'he, cp0_epc_i=32'h0000_1234 -> stall=0, flush=1, new_pc=32'h1234, flush_count_o=1 next cycle.
- Recover mask: exc cycle, then next cycle stallreq_from_ex=1 and stallreq_from_if=1 -> stall=6'b000011. Following cycle stallreq_from_ex=1 -> stall=6'b001111.
- Watchdog with WDOG_LIMIT=4: stallreq_from_mem held 4 cycles -> stall_timeout_o=1 after the 4th edge. Drop request -> flag stays 1. stall_cycles_o=4.
- Interrupt vector: excepttype_i=32'h1 -> new_pc=32'h20. Unknown code 32'h7 -> new_pc=32'h40.
